// File: rtl/pnl_bram_pkg.sv
// Shared constants and FSM state type for the PNL block-RAM controller.
package pnl_bram_pkg;

    localparam int unsigned PNL_ADDR_WIDTH = 13;
    localparam int unsigned PNL_DATA_WIDTH = 16;
    localparam int unsigned PNL_NUM_WORDS  = 8192;

    localparam logic MODE_LOAD   = 1'b0;
    localparam logic MODE_UNLOAD = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_REQ = 3'd1,
        WRITE    = 3'd2,
        RD_WAIT  = 3'd3,
        ACK      = 3'd4,
        DONE     = 3'd5
    } pnl_ctrl_state_t;

endpackage

// File: rtl/pnl_rd_delay.sv
// Counts RD_LAT cycles while run is high and strobes capture on the last one.
module pnl_rd_delay #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic capture
);

    localparam int unsigned CW = 2;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign capture = run && (cnt_q == CW'(RD_LAT - 1));

    // Counter restarts from zero on every entry into the read wait.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!run || capture) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pnl_bram_ctrl.sv
// Host four-phase handshake to BRAM port A: loads or unloads N words from address 0.
module pnl_bram_ctrl
    import pnl_bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = PNL_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PNL_DATA_WIDTH,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  Clk,
    input  logic                  RESET_N,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH:0]   num_words,
    input  logic                  req,
    output logic                  ack,
    input  logic [DATA_WIDTH-1:0] host_din,
    output logic [DATA_WIDTH-1:0] host_dout,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] BRAM_PORTA_addr,
    output logic [DATA_WIDTH-1:0] BRAM_PORTA_dout,
    input  logic [DATA_WIDTH-1:0] BRAM_PORTA_din,
    output logic                  BRAM_PORTA_we
);

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    pnl_ctrl_state_t       state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH:0]   nwords_q, nwords_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  we_q, we_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  len_ok;
    logic                  rd_run;
    logic                  rd_capture;

    assign len_ok  = (num_words != '0) && (num_words <= MAX_WORDS);
    assign cnt_inc = cnt_q + 1'b1;
    assign rd_run  = (state_q == RD_WAIT);

    pnl_rd_delay #(
        .RD_LAT (RD_LAT)
    ) u_rd_delay (
        .clk     (Clk),
        .rst_n   (RESET_N),
        .run     (rd_run),
        .capture (rd_capture)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        nwords_d = nwords_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        we_d     = 1'b0;
        ack_d    = ack_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                addr_d = '0;
                if (start) begin
                    if (len_ok) begin
                        mode_d   = mode;
                        nwords_d = num_words;
                        state_d  = WAIT_REQ;
                    end else begin
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            WAIT_REQ: begin
                if (req) begin
                    if (mode_q == MODE_LOAD) begin
                        wdata_d = host_din;
                        we_d    = 1'b1;
                        state_d = WRITE;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            WRITE: begin
                ack_d   = 1'b1;
                state_d = ACK;
            end
            RD_WAIT: begin
                if (rd_capture) begin
                    rdata_d = BRAM_PORTA_din;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                // Address only advances when another word follows, so it never wraps.
                if (!req) begin
                    ack_d = 1'b0;
                    cnt_d = cnt_inc;
                    if (cnt_inc == nwords_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = WAIT_REQ;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            mode_q   <= MODE_LOAD;
            nwords_q <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            nwords_q <= nwords_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
        end
    end

    assign ack             = ack_q;
    assign host_dout       = rdata_q;
    assign ready           = ready_q;
    assign done            = done_q;
    assign err             = err_q;
    assign BRAM_PORTA_addr = addr_q;
    assign BRAM_PORTA_dout = wdata_q;
    assign BRAM_PORTA_we   = we_q;

endmodule

// File: doc/pnl_bram_ctrl.md
# pnl_bram_ctrl

PS-facing controller that fills and drains the 8K×16 PNL block RAM (`design_1_blk_mem_gen_0_0`, port A) one word at a time. It sits directly upstream of the BRAM, and its host side is a GPIO-level four-phase handshake. In load mode it writes N host words to consecutive addresses from 0. In unload mode it reads N words back to the host. It owns all of BRAM port A while busy.

## Interface
- `ADDR_WIDTH`, 13: BRAM address width.
- `DATA_WIDTH`, 16: BRAM word width.
- `RD_LAT`, 1: BRAM read latency in cycles; legal values are 1 or 2.
- `Clk` in 1: the single clock.
- `RESET_N` in 1: reset, synchronous and active-low.
- `start` in 1: level; high requests a transfer, sampled only in IDLE.
- `mode` in 1: 0 = load (host→BRAM), 1 = unload (BRAM→host); latched at start.
- `num_words` in ADDR_WIDTH+1: transfer length; legal range 1..8192; latched at start.
- `req` in 1: host word request (four-phase).
- `ack` out 1: controller acknowledge (four-phase).
- `host_din` in DATA_WIDTH: load data, valid while `req`=1.
- `host_dout` out DATA_WIDTH: unload data, valid while `ack`=1.
- `ready` out 1: high in IDLE only.
- `done` out 1: transfer finished; held until `start` is low.
- `err` out 1: illegal `num_words`; valid with `done`.
- `BRAM_PORTA_addr` out ADDR_WIDTH: BRAM address.
- `BRAM_PORTA_dout` out DATA_WIDTH: write data to BRAM `dina`.
- `BRAM_PORTA_din` in DATA_WIDTH: read data from BRAM `douta`.
- `BRAM_PORTA_we` out 1: BRAM write enable.

## Operation
- States: IDLE, WAIT_REQ, WRITE, RD_WAIT, ACK, DONE.
- IDLE: `ready`=1, and the word counter and address are cleared to 0.
  - `start`=1 with `num_words` in 1..8192: latch `mode` and `num_words`, go to WAIT_REQ.
  - `start`=1 with `num_words` 0 or >8192: go to DONE with `err`=1. No BRAM access occurs.
- WAIT_REQ: wait for `req`=1.
  - Load: latch `host_din` into `BRAM_PORTA_dout`, go to WRITE.
  - Unload: go to RD_WAIT.
- WRITE: `BRAM_PORTA_we`=1 for exactly this one cycle at the current address, then go to ACK.
- RD_WAIT: hold the address for `RD_LAT` cycles. On the last cycle, capture `BRAM_PORTA_din` into `host_dout`, then go to ACK.
- ACK: `ack`=1 until `req`=0 is sampled. On that edge:
  - `ack` goes to 0.
  - The counter increments.
  - If counter+1 = `num_words`, go to DONE. Otherwise increment the address and go to WAIT_REQ.
- The address never wraps. A transfer of 8192 words ends at address 8191.
- DONE: `done`=1. When `start`=0 is sampled, go to IDLE and clear `done` and `err`.
- Asserting `start` while not in IDLE has no effect. Changes to `mode` or `num_words` mid-transfer have no effect.
- `host_dout` holds its last captured value until the next capture.

## Timing
- Reset values (synchronous, taking effect on the first rising edge with `RESET_N`=0):
  - State is IDLE.
  - `ready`=1.
  - `ack`, `done`, `err`, and `BRAM_PORTA_we` are 0.
  - `BRAM_PORTA_addr`, `BRAM_PORTA_dout`, `host_dout`, and the counter are 0.
- Reset mid-transfer aborts immediately. BRAM contents are untouched; a write in progress in that cycle is suppressed because `we` resets to 0.
- From `start` sampled high to WAIT_REQ: 1 cycle.
- Load word: `req` sampled → `we`=1 the next cycle → `ack`=1 the cycle after. That is 2 cycles from `req` to `ack`.
- Unload word: `req` sampled → `ack`=1 after 1+`RD_LAT` cycles. `host_dout` is valid in the same cycle `ack` rises.
- `req` falling sampled → `ack`=0 the next cycle. The address update and the move to DONE happen on the same edge.
- The minimum word period is 4 cycles (load) or 3+`RD_LAT` cycles (unload), assuming the host responds in 1 cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `pnl_bram_pkg` holds:
  - `PNL_ADDR_WIDTH`=13 and `PNL_DATA_WIDTH`=16.
  - `PNL_NUM_WORDS`=8192.
  - `MODE_LOAD`=0 and `MODE_UNLOAD`=1.
  - The `pnl_ctrl_state_t` enum.
- Sub-module `pnl_rd_delay` is a counter that counts `RD_LAT` cycles and pulses a capture strobe. It is instantiated once.
- The FSM, counter, and address register live in the top level.

## Test plan
- Reset: hold `RESET_N`=0 for 5 cycles → all outputs take their reset values, `ready`=1.
- Load 4 words: `mode`=0, `num_words`=4, host sends 0x1111, 0x2222, 0x3333, 0xABCD → one `we` pulse each at addresses 0..3 with matching `dout`. Then `done`=1, `err`=0, and dropping `start` returns `ready`=1.
- Unload 4 words after the load above, with `RD_LAT`=1 and then `RD_LAT`=2 → `host_dout` returns 0x1111, 0x2222, 0x3333, 0xABCD, each valid when `ack` rises at the stated latency.
- Bounds:
  - `num_words`=0 → `done`=`err`=1 with no `we` pulse.
  - `num_words`=8193 → same result.
  - `num_words`=8192 → the last write is at 8191 and address 0 is not rewritten.
- Reset mid-load: assert `RESET_N`=0 during WRITE of word 2 → `we`=0 on the next edge and the FSM is in IDLE. Words 0 and 1 remain in the BRAM.
- Busy stimulus: toggle `start` and `mode` during a load, and hold `req` high across `ack` → no extra writes occur, and exactly one `ack` is issued per `req` cycle.
